// File: rtl/ice_bus_master_tx.sv
// ice_bus_master_tx
// Buffers host bytes in a small FIFO and replays them as framed transfers on
// the master bus: SETUP presents the frame address, each DATA cycle strobes one
// byte, GAP separates bytes, TRAIL closes the frame. A receiver overflow aborts
// the frame and the remainder of that frame is flushed from the FIFO.
//
// Ports
//   CLK, RESETn          : clock (rising edge) and asynchronous active-low reset
//   host_addr/data       : byte to push with its frame address
//   host_valid/last      : push request / final byte of the frame
//   host_ready           : FIFO can accept a byte
//   ma_addr/ma_data      : registered master-bus address and data
//   ma_data_valid        : one-cycle strobe per byte
//   ma_frame_valid       : high for the whole frame
//   sl_overflow          : receiver overflow, aborts the current frame
//   tx_done / tx_err     : one-cycle pulse on frame completion / abort
//   frame_count          : completed frames, wraps 255 -> 0
module ice_bus_master_tx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       host_last,
    output logic       host_ready,
    output logic [7:0] ma_addr,
    output logic [7:0] ma_data,
    output logic       ma_data_valid,
    output logic       ma_frame_valid,
    input  logic       sl_overflow,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_DATA  = 3'd2,
        ST_GAP   = 3'd3,
        ST_TRAIL = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    // FIFO storage: entry = {last, addr, data}
    logic [16:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] count_s;
    logic        empty_s;
    logic        full_s;
    logic        push_s;
    logic        pop_s;
    logic [16:0] head_s;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  ma_addr_q, ma_addr_d;
    logic [7:0]  ma_data_q, ma_data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_valid_q, frame_valid_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_err_q, tx_err_d;
    logic [7:0]  frame_count_q, frame_count_d;

    // Extra pointer bit distinguishes full from empty.
    assign count_s    = wr_ptr_q - rd_ptr_q;
    assign empty_s    = (count_s == '0);
    assign full_s     = (count_s == DEPTH_C);
    assign push_s     = host_valid && !full_s;
    assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
    assign host_ready = !full_s;

    // FIFO pointers and storage
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 17'd0;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {host_last, host_addr, host_data};
                wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    // Next-state, pop control and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        pop_s         = 1'b0;
        tx_err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) state_d = ST_SETUP;
                else          state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (sl_overflow) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_FLUSH;
                end else begin
                    pop_s    = 1'b1;
                    last_d   = head_s[16];
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // last_q describes the byte popped on entry to DATA
                if (sl_overflow) begin
                    tx_err_d = 1'b1;
                    state_d  = last_q ? ST_IDLE : ST_FLUSH;
                end else begin
                    state_d  = last_q ? ST_TRAIL : ST_GAP;
                end
            end
            ST_GAP: begin
                if (sl_overflow) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_FLUSH;
                end else if (!empty_s) begin
                    pop_s    = 1'b1;
                    last_d   = head_s[16];
                    state_d  = ST_DATA;
                end else begin
                    state_d  = ST_GAP;
                end
            end
            ST_TRAIL: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = head_s[16] ? ST_IDLE : ST_FLUSH;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered and reflect the state being entered.
        frame_valid_d = (state_d == ST_SETUP) || (state_d == ST_DATA) ||
                        (state_d == ST_GAP)   || (state_d == ST_TRAIL);
        data_valid_d  = (state_d == ST_DATA);

        if ((state_q == ST_IDLE) && (state_d == ST_SETUP)) ma_addr_d = head_s[15:8];
        else                                                 ma_addr_d = ma_addr_q;

        if (pop_s && (state_d == ST_DATA)) ma_data_d = head_s[7:0];
        else                               ma_data_d = ma_data_q;

        tx_done_d = (state_q == ST_TRAIL);
        if (tx_done_d) frame_count_d = frame_count_q + 8'd1;
        else           frame_count_d = frame_count_q;
    end

    // State and registered output flops
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b0;
            ma_addr_q     <= 8'd0;
            ma_data_q     <= 8'd0;
            data_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_err_q      <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            ma_addr_q     <= ma_addr_d;
            ma_data_q     <= ma_data_d;
            data_valid_q  <= data_valid_d;
            frame_valid_q <= frame_valid_d;
            tx_done_q     <= tx_done_d;
            tx_err_q      <= tx_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign ma_addr        = ma_addr_q;
    assign ma_data        = ma_data_q;
    assign ma_data_valid  = data_valid_q;
    assign ma_frame_valid = frame_valid_q;
    assign tx_done        = tx_done_q;
    assign tx_err         = tx_err_q;
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_ice_bus_master_tx.sv
// Directed bench for ice_bus_master_tx with a scoreboard of expected bytes.
module tb_ice_bus_master_tx;

    logic       CLK;
    logic       RESETn;
    logic [7:0] host_addr;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_last;
    logic       host_ready;
    logic [7:0] ma_addr;
    logic [7:0] ma_data;
    logic       ma_data_valid;
    logic       ma_frame_valid;
    logic       sl_overflow;
    logic       tx_done;
    logic       tx_err;
    logic [7:0] frame_count;

    ice_bus_master_tx #(.FIFO_DEPTH(8)) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .host_valid     (host_valid),
        .host_last      (host_last),
        .host_ready     (host_ready),
        .ma_addr        (ma_addr),
        .ma_data        (ma_data),
        .ma_data_valid  (ma_data_valid),
        .ma_frame_valid (ma_frame_valid),
        .sl_overflow    (sl_overflow),
        .tx_done        (tx_done),
        .tx_err         (tx_err),
        .frame_count    (frame_count)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         nstrobes = 0;
    bit         tight = 1'b0;
    bit         prev_fv = 1'b0;
    logic [7:0] last_data = 8'd0;
    bit         new_frame = 1'b1;
    logic [7:0] cur_addr = 8'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push one byte, waiting (bounded) for host_ready; keep=0 marks a byte that will be flushed.
    task automatic push_byte(input logic [7:0] a, input logic [7:0] d, input bit last, input bit keep);
        bit ok;
        ok = 1'b0;
        if (new_frame) cur_addr = a;
        host_addr  = a;
        host_data  = d;
        host_last  = last;
        host_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = host_ready;
            @(posedge CLK); #1;
        end
        host_valid = 1'b0;
        if (!ok) check(32'(ok), 32'd1, "push_timeout");
        else if (keep) exp_q.push_back({cur_addr, d});
        new_frame = last;
    endtask

    // Wait until every expected byte came out and the frame closed.
    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !ma_frame_valid) break;
            @(posedge CLK); #1;
        end
        check(32'(exp_q.size()), 32'd0, "drain_timeout");
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (!RESETn) begin
            last_data = 8'd0;
            prev_fv   = 1'b0;
            nstrobes  = 0;
        end else begin
            if (ma_frame_valid && !prev_fv && exp_q.size() > 0)
                check(32'(ma_addr), 32'(exp_q[0].addr), "frame_addr");
            if (ma_data_valid) begin
                check(32'(ma_frame_valid), 32'd1, "fv_with_dv");
                if (exp_q.size() == 0) begin
                    check(32'(exp_q.size()), 32'd1, "unexpected_strobe");
                end else begin
                    e = exp_q.pop_front();
                    check(32'({ma_addr, ma_data}), 32'(e), "strobe");
                end
                if (tight && nstrobes > 0) check(32'(cyc - last_cyc), 32'd2, "strobe_spacing");
                last_cyc  = cyc;
                nstrobes++;
                last_data = ma_data;
            end else begin
                check(32'(ma_data), 32'(last_data), "data_hold");
            end
            if (!ma_frame_valid) nstrobes = 0;
            if (tx_done || tx_err) check(32'(tx_done && tx_err), 32'd0, "done_err_excl");
            if (tx_done) begin
                done_cnt++;
                check(32'(ma_frame_valid), 32'd0, "idle_after_frame");
            end
            if (tx_err) err_cnt++;
            prev_fv = ma_frame_valid;
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv_cycles;
        int done0;
        bit seen;
        RESETn      = 1'b0;
        host_addr   = 8'd0;
        host_data   = 8'd0;
        host_valid  = 1'b0;
        host_last   = 1'b0;
        sl_overflow = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check(32'(host_ready), 32'd1, "rst_host_ready");
        check(32'(ma_frame_valid), 32'd0, "rst_fv");
        check(32'(ma_data_valid), 32'd0, "rst_dv");
        check(32'({ma_addr, ma_data}), 32'd0, "rst_addr_data");
        check(32'(frame_count), 32'd0, "rst_frame_count");
        RESETn = 1'b1;
        @(posedge CLK); #1;

        // Single one-byte frame
        push_byte(8'h5A, 8'h3C, 1'b1, 1'b1);
        fv_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (ma_frame_valid) fv_cycles++;
        end
        check(32'(fv_cycles), 32'd3, "single_fv_cycles");
        check(32'(exp_q.size()), 32'd0, "single_consumed");
        check(32'(done_cnt), 32'd1, "single_done");
        check(32'(frame_count), 32'd1, "single_frame_count");

        // 4-byte frame then 2-byte frame, back to back
        tight = 1'b1;
        push_byte(8'h21, 8'h01, 1'b0, 1'b1);
        push_byte(8'hFF, 8'h02, 1'b0, 1'b1);
        push_byte(8'hFF, 8'h03, 1'b0, 1'b1);
        push_byte(8'hFF, 8'h04, 1'b1, 1'b1);
        push_byte(8'h34, 8'h81, 1'b0, 1'b1);
        push_byte(8'h00, 8'h82, 1'b1, 1'b1);
        wait_drain();
        tight = 1'b0;
        check(32'(done_cnt), 32'd3, "b2b_done");
        check(32'(frame_count), 32'd3, "b2b_frame_count");

        // FIFO_DEPTH+2 one-byte frames pushed back to back fill the FIFO
        for (int i = 0; i < 10; i++) begin
            push_byte(8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b1, 1'b1);
        end
        check(32'(host_ready), 32'd0, "full_host_ready");
        wait_drain();
        check(32'(host_ready), 32'd1, "drained_host_ready");
        check(32'(frame_count), 32'd13, "fill_frame_count");

        // Host stalls mid-frame: frame_valid holds in GAP
        push_byte(8'h77, 8'h51, 1'b0, 1'b1);
        push_byte(8'h78, 8'h52, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check(32'(ma_frame_valid), 32'd1, "stall_fv");
        end
        push_byte(8'h79, 8'h53, 1'b1, 1'b1);
        wait_drain();
        check(32'(frame_count), 32'd14, "stall_frame_count");

        // Overflow during the 2nd byte of a 5-byte frame, then a 1-byte frame
        done0 = done_cnt;
        push_byte(8'h90, 8'h01, 1'b0, 1'b1);
        push_byte(8'h90, 8'h02, 1'b0, 1'b1);
        push_byte(8'h90, 8'h03, 1'b0, 1'b0);
        push_byte(8'h90, 8'h04, 1'b0, 1'b0);
        push_byte(8'h90, 8'h05, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (ma_data_valid && ma_data == 8'h02) seen = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        check(32'(seen), 32'd1, "ovf_second_byte_seen");
        sl_overflow = 1'b1;
        @(posedge CLK); #1;
        sl_overflow = 1'b0;
        check(32'(tx_err), 32'd1, "ovf_tx_err");
        check(32'({ma_frame_valid, ma_data_valid}), 32'd0, "ovf_outputs_dropped");
        push_byte(8'hC3, 8'hEE, 1'b1, 1'b1);
        wait_drain();
        check(32'(err_cnt), 32'd1, "ovf_err_count");
        check(32'(done_cnt - done0), 32'd1, "ovf_done_count");
        check(32'(frame_count), 32'd15, "ovf_frame_count");

        // Reset asserted during DATA
        push_byte(8'h42, 8'h61, 1'b0, 1'b1);
        push_byte(8'h42, 8'h62, 1'b0, 1'b1);
        push_byte(8'h42, 8'h63, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (ma_data_valid) seen = 1'b1;
            else begin @(posedge CLK); #1; end
        end
        check(32'(seen), 32'd1, "rst_data_seen");
        #1;
        RESETn = 1'b0;
        #1;
        exp_q.delete();
        check(32'({ma_frame_valid, ma_data_valid, tx_done, tx_err}), 32'd0, "midrst_flags");
        check(32'({ma_addr, ma_data}), 32'd0, "midrst_addr_data");
        check(32'(frame_count), 32'd0, "midrst_frame_count");
        check(32'(host_ready), 32'd1, "midrst_host_ready");
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        new_frame = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (ma_frame_valid || ma_data_valid) seen = 1'b1;
        end
        check(32'(seen), 32'd0, "post_rst_no_partial");
        check(32'(host_ready), 32'd1, "post_rst_host_ready");
        done0 = done_cnt;
        push_byte(8'h11, 8'h22, 1'b1, 1'b1);
        wait_drain();
        check(32'(done_cnt - done0), 32'd1, "post_rst_done");
        check(32'(frame_count), 32'd1, "post_rst_frame_count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
